// File: rtl/multi_pulse_stretcher_if.sv
// Control and status bundle for multi_pulse_stretcher.
// The master drives the trigger side and the slave (the stretcher) drives the pulses.
interface multi_pulse_stretcher_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 16
);
  logic                clear;
  logic [WIDTH-1:0]    len;
  logic [CHANNELS-1:0] retrig;
  logic [CHANNELS-1:0] in;
  logic [CHANNELS-1:0] out;
  logic                busy;

  modport master (
    output clear,
    output len,
    output retrig,
    output in,
    input  out,
    input  busy
  );

  modport slave (
    input  clear,
    input  len,
    input  retrig,
    input  in,
    output out,
    output busy
  );
endinterface

// File: rtl/multi_pulse_stretcher.sv
// Multi-channel pulse stretcher with optional retrigger and a forced low gap.
// Each channel turns a synchronous trigger into a registered pulse of len cycles
// (len = 0 means 2^WIDTH). When GAP > 0, each pulse is followed by GAP forced-low cycles.
module multi_pulse_stretcher #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned GAP      = 0
) (
  input logic                    clk,
  input logic                    rst,
  multi_pulse_stretcher_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StActive, StGap} state_e;

  localparam bit               HasGap  = (GAP != 0);
  localparam logic [WIDTH-1:0] GapLoad = WIDTH'(GAP);
  localparam logic [WIDTH-1:0] One     = WIDTH'(1);

  state_e              state_q [CHANNELS];
  logic [WIDTH-1:0]    cnt_q   [CHANNELS];
  logic [WIDTH-1:0]    gcnt_q  [CHANNELS];
  logic [CHANNELS-1:0] out_q;
  logic                busy_q;

  logic [CHANNELS-1:0] stay_busy;
  logic                any_busy;

  // Per-channel "not IDLE after this edge" flags that feed the registered busy.
  always_comb begin
    stay_busy = '0;
    any_busy  = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      any_busy = any_busy | (state_q[c] != StIdle);
      case (state_q[c])
        StIdle:   stay_busy[c] = bus.in[c];
        StActive: stay_busy[c] = HasGap || (bus.retrig[c] && bus.in[c]) || (cnt_q[c] != One);
        StGap:    stay_busy[c] = (gcnt_q[c] != One);
        default:  stay_busy[c] = 1'b0;
      endcase
    end
  end

  // Per-channel FSMs with registered pulse outputs and the shared busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= StIdle;
        cnt_q[c]   <= '0;
        gcnt_q[c]  <= '0;
      end
      out_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (bus.clear) begin
          state_q[c] <= StIdle;
          out_q[c]   <= 1'b0;
        end else begin
          case (state_q[c])
            StIdle: begin
              if (bus.in[c]) begin
                state_q[c] <= StActive;
                cnt_q[c]   <= bus.len;
                out_q[c]   <= 1'b1;
              end
            end
            StActive: begin
              if (bus.retrig[c] && bus.in[c]) begin
                cnt_q[c] <= bus.len;
              end else if (cnt_q[c] == One) begin
                out_q[c] <= 1'b0;
                if (HasGap) begin
                  state_q[c] <= StGap;
                  gcnt_q[c]  <= GapLoad;
                end else begin
                  state_q[c] <= StIdle;
                end
              end else begin
                // A load of 0 wraps through all-ones, giving 2^WIDTH high cycles.
                cnt_q[c] <= cnt_q[c] - One;
              end
            end
            StGap: begin
              // Triggers are dropped here, not queued.
              if (gcnt_q[c] == One) begin
                state_q[c] <= StIdle;
              end else begin
                gcnt_q[c] <= gcnt_q[c] - One;
              end
            end
            default: begin
              state_q[c] <= StIdle;
              out_q[c]   <= 1'b0;
            end
          endcase
        end
      end
      // On clear, busy reflects the channels as they were and drops one edge later.
      busy_q <= bus.clear ? any_busy : (|stay_busy);
    end
  end

  assign bus.out  = out_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_multi_pulse_stretcher.sv
// Directed bench for multi_pulse_stretcher: one instance with GAP = 0, WIDTH = 16
// and one with GAP = 3, WIDTH = 4, both on a shared clock and reset.
module tb_multi_pulse_stretcher;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   errs  = 0;

  always #5 clk = ~clk;

  multi_pulse_stretcher_if #(.CHANNELS(4), .WIDTH(16)) ia ();
  multi_pulse_stretcher_if #(.CHANNELS(4), .WIDTH(4))  ib ();

  multi_pulse_stretcher #(.CHANNELS(4), .WIDTH(16), .GAP(0)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ia.slave)
  );

  multi_pulse_stretcher #(.CHANNELS(4), .WIDTH(4), .GAP(3)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ib.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ca(input string tag, input logic [3:0] o, input logic b);
    chk({"a_", tag, "_out"}, {28'd0, ia.out}, {28'd0, o});
    chk({"a_", tag, "_busy"}, {31'd0, ia.busy}, {31'd0, b});
  endtask

  task automatic cb(input string tag, input logic [3:0] o, input logic b);
    chk({"b_", tag, "_out"}, {28'd0, ib.out}, {28'd0, o});
    chk({"b_", tag, "_busy"}, {31'd0, ib.busy}, {31'd0, b});
  endtask

  // Step past the next rising edge; inputs set after this are sampled at the following edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    ia.clear = 1'b0; ia.len = '0; ia.retrig = '0; ia.in = '0;
    ib.clear = 1'b0; ib.len = '0; ib.retrig = '0; ib.in = '0;
    #3;
    ca("reset", 4'h0, 1'b0);
    cb("reset", 4'h0, 1'b0);
    tick; tick;
    rst = 1'b0;
    tick;

    // Single trigger, len = 5: five high cycles on channel 0 only.
    ia.len = 16'd5; ia.in = 4'b0001;
    tick; ia.in = '0;
    ca("t1_start", 4'h1, 1'b1);
    for (int i = 1; i < 5; i++) begin
      tick; ca("t1_hold", 4'h1, 1'b1);
    end
    tick; ca("t1_end", 4'h0, 1'b0);
    tick; ca("t1_idle", 4'h0, 1'b0);

    // Retriggerable, len = 4, triggers at t0 and t0+3: seven high cycles.
    ia.retrig = 4'b0010; ia.len = 16'd4; ia.in = 4'b0010;
    tick; ia.in = '0;
    ca("rt_t0", 4'h2, 1'b1);
    tick; ca("rt_t1", 4'h2, 1'b1);
    tick; ca("rt_t2", 4'h2, 1'b1);
    ia.in = 4'b0010;
    tick; ia.in = '0;
    ca("rt_t3", 4'h2, 1'b1);
    for (int i = 4; i < 7; i++) begin
      tick; ca("rt_hold", 4'h2, 1'b1);
    end
    tick; ca("rt_end", 4'h0, 1'b0);

    // One-shot, same stimulus: four high cycles, second trigger ignored.
    ia.retrig = '0; ia.in = 4'b0010;
    tick; ia.in = '0;
    ca("os_t0", 4'h2, 1'b1);
    tick; ca("os_t1", 4'h2, 1'b1);
    tick; ca("os_t2", 4'h2, 1'b1);
    ia.in = 4'b0010;
    tick; ia.in = '0;
    ca("os_t3", 4'h2, 1'b1);
    tick; ca("os_end", 4'h0, 1'b0);
    tick; ca("os_idle", 4'h0, 1'b0);

    // GAP = 0, in held, len = 2: period 3 (two high, one IDLE cycle).
    ia.len = 16'd2; ia.in = 4'b1000;
    for (int p = 0; p < 2; p++) begin
      tick; ca("g0_h0", 4'h8, 1'b1);
      tick; ca("g0_h1", 4'h8, 1'b1);
      tick; ca("g0_lo", 4'h0, 1'b0);
    end
    ia.in = '0;
    tick; ca("g0_idle", 4'h0, 1'b0);

    // GAP = 3, in held, len = 2: two high, three GAP cycles, one IDLE cycle.
    ib.len = 4'd2; ib.in = 4'b0100;
    for (int p = 0; p < 2; p++) begin
      tick; cb("g3_h0", 4'h4, 1'b1);
      tick; cb("g3_h1", 4'h4, 1'b1);
      for (int g = 0; g < 3; g++) begin
        tick; cb("g3_gap", 4'h0, 1'b1);
      end
      tick; cb("g3_idle", 4'h0, 1'b0);
    end
    ib.in = '0;
    tick; cb("g3_rest", 4'h0, 1'b0);

    // WIDTH = 4, len = 0: sixteen high cycles; len change mid-pulse applies next time.
    ib.len = 4'd0; ib.in = 4'b0001;
    tick; ib.in = '0;
    cb("w_t0", 4'h1, 1'b1);
    for (int i = 1; i < 16; i++) begin
      tick; cb("w_hold", 4'h1, 1'b1);
      if (i == 5) ib.len = 4'd2;
    end
    tick; cb("w_gap0", 4'h0, 1'b1);
    tick; cb("w_gap1", 4'h0, 1'b1);
    tick; cb("w_gap2", 4'h0, 1'b1);
    tick; cb("w_idle", 4'h0, 1'b0);
    ib.in = 4'b0001;
    tick; ib.in = '0;
    cb("w2_t0", 4'h1, 1'b1);
    tick; cb("w2_t1", 4'h1, 1'b1);
    tick; cb("w2_end", 4'h0, 1'b1);
    repeat (4) tick;
    cb("w2_idle", 4'h0, 1'b0);

    // Clear with a simultaneous trigger while all channels are active.
    ia.len = 16'd10; ia.in = 4'hF;
    tick; ia.in = '0;
    ca("cl_all", 4'hF, 1'b1);
    tick; ca("cl_run", 4'hF, 1'b1);
    ia.clear = 1'b1; ia.in = 4'hF;
    tick; ia.clear = 1'b0; ia.in = '0;
    ca("cl_edge", 4'h0, 1'b1);
    tick; ca("cl_next", 4'h0, 1'b0);
    tick; ca("cl_quiet", 4'h0, 1'b0);

    // Asynchronous reset mid-pulse (A) and mid-gap (B).
    ia.len = 16'd10; ia.in = 4'b0001;
    ib.len = 4'd1;   ib.in = 4'b0010;
    tick; ia.in = '0; ib.in = '0;
    ca("rs_pulse", 4'h1, 1'b1);
    cb("rs_pulse", 4'h2, 1'b1);
    tick;
    ca("rs_mid", 4'h1, 1'b1);
    cb("rs_ingap", 4'h0, 1'b1);
    #2 rst = 1'b1;
    #1;
    ca("rs_async", 4'h0, 1'b0);
    cb("rs_async", 4'h0, 1'b0);
    #1 rst = 1'b0;
    tick;
    ca("rs_after", 4'h0, 1'b0);
    cb("rs_after", 4'h0, 1'b0);
    ia.len = 16'd3; ia.in = 4'b0001;
    tick; ia.in = '0;
    ca("rs_p0", 4'h1, 1'b1);
    tick; ca("rs_p1", 4'h1, 1'b1);
    tick; ca("rs_p2", 4'h1, 1'b1);
    tick; ca("rs_pend", 4'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
